// File: rtl/matrix_seq_ctrl.sv
// Row sequencer for the 40-bit five-lane row ALU: walks rows 0..N-1 of banks A/B,
// masks unused columns, writes result rows and reports sticky overflow and done.
module matrix_seq_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [2:0]        size_i,
  input  logic [7:0]        scalar_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_flag_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [39:0]       rd_data_a_i,
  input  logic [39:0]       rd_data_b_i,
  output logic [2:0]        alu_op_o,
  output logic [39:0]       alu_r1_o,
  output logic [39:0]       alu_r2_o,
  output logic [2:0]        alu_s_o,
  input  logic [39:0]       alu_outr_i,
  input  logic              alu_ovf_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [39:0]       wr_data_o
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SMUL = 3'b011;
  localparam logic [2:0] OP_OPP = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  state_t             state_q;
  logic [ADDR_W-1:0]  row_q;
  logic [2:0]         op_q;
  logic [2:0]         size_q;
  logic [7:0]         scalar_q;
  logic [2:0]         alu_op_q;
  logic               err_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_en_q;
  logic               wr_en_q;

  logic               op_ok;
  logic               size_ok;
  logic [2:0]         alu_op_d;
  logic [ADDR_W-1:0]  row_last;
  logic [4:0]         lane_en;
  logic [39:0]        a_m;
  logic [39:0]        b_m;
  logic [39:0]        out_m;
  logic [39:0]        r1_d;
  logic [39:0]        r2_d;

  assign op_ok    = (op_i == OP_ADD) || (op_i == OP_SUB) || (op_i == OP_SMUL) ||
                    (op_i == OP_OPP) || (op_i == OP_CLR);
  assign size_ok  = (size_i >= 3'd2) && (size_i <= 3'd5);
  // Opposite is computed on the ALU as 0 - A, so it issues a subtract.
  assign alu_op_d = (op_i == OP_OPP) ? OP_SUB : op_i;
  assign row_last = ADDR_W'(size_q - 3'd1);

  for (genvar gi = 0; gi < 5; gi++) begin : g_lane
    assign lane_en[gi]        = (size_q > 3'(gi));
    assign a_m[8*gi +: 8]     = rd_data_a_i[8*gi +: 8] & {8{lane_en[gi]}};
    assign b_m[8*gi +: 8]     = rd_data_b_i[8*gi +: 8] & {8{lane_en[gi]}};
    assign out_m[8*gi +: 8]   = alu_outr_i[8*gi +: 8] & {8{lane_en[gi]}};
  end

  always_comb begin
    r1_d = '0;
    r2_d = '0;
    if (wr_en_q) begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          r1_d = a_m;
          r2_d = b_m;
        end
        OP_SMUL: begin
          r1_d = a_m;
          r2_d = {32'd0, scalar_q};
        end
        OP_OPP: r2_d = a_m;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      row_q    <= '0;
      op_q     <= '0;
      size_q   <= '0;
      scalar_q <= '0;
      alu_op_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            size_q   <= size_i;
            scalar_q <= scalar_i;
            alu_op_q <= alu_op_d;
            ovf_q    <= 1'b0;
            row_q    <= '0;
            busy_q   <= 1'b1;
            if (op_ok && size_ok) begin
              err_q   <= 1'b0;
              rd_en_q <= 1'b1;
              state_q <= READ;
            end else begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        READ: begin
          wr_en_q <= 1'b1;
          state_q <= EXEC;
        end
        EXEC: begin
          // Clear never drives the ALU, so whatever it reports is ignored.
          if (op_q != OP_CLR) ovf_q <= ovf_q | alu_ovf_i;
          if (row_q == row_last) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            row_q   <= row_q + ADDR_W'(1);
            rd_en_q <= 1'b1;
            state_q <= READ;
          end
        end
        DONE: begin
          busy_q   <= 1'b0;
          alu_op_q <= '0;
          size_q   <= '0;
          row_q    <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign ovf_flag_o = ovf_q;
  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = rd_en_q ? row_q : '0;
  assign alu_op_o   = alu_op_q;
  assign alu_s_o    = size_q;
  assign alu_r1_o   = r1_d;
  assign alu_r2_o   = r2_d;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_en_q ? row_q : '0;
  assign wr_data_o  = (wr_en_q && op_q != OP_CLR) ? out_m : '0;

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Directed bench for matrix_seq_ctrl: registered operand banks, a lane-wise ALU
// model, a command vector table and hand sequences for reset and busy restart.
module tb_matrix_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  size;
  logic [7:0]  scalar;
  logic        busy, done, err, ovf_flag, rd_en, wr_en;
  logic [2:0]  rd_addr, wr_addr;
  logic [39:0] rd_data_a, rd_data_b;
  logic [2:0]  alu_op, alu_s;
  logic [39:0] alu_r1, alu_r2, alu_outr, wr_data;
  logic        alu_ovf;

  logic [39:0] bank_a [0:7];
  logic [39:0] bank_b [0:7];

  int total = 0;
  int bad = 0;
  logic prev_err = 1'b0;
  logic prev_ovf = 1'b0;

  always #5 clk = ~clk;

  matrix_seq_ctrl #(.ADDR_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .size_i(size),
    .scalar_i(scalar), .busy_o(busy), .done_o(done), .err_o(err),
    .ovf_flag_o(ovf_flag), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_a_i(rd_data_a), .rd_data_b_i(rd_data_b), .alu_op_o(alu_op),
    .alu_r1_o(alu_r1), .alu_r2_o(alu_r2), .alu_s_o(alu_s),
    .alu_outr_i(alu_outr), .alu_ovf_i(alu_ovf), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= bank_a[rd_addr];
      rd_data_b <= bank_b[rd_addr];
    end
  end

  // Lane-wise signed ALU; unknown opcodes flag overflow so a leak would show.
  always_comb begin
    logic signed [7:0] la;
    logic signed [7:0] lb;
    int r;
    alu_outr = '0;
    alu_ovf  = 1'b0;
    for (int j = 0; j < 5; j++) begin
      la = alu_r1[8*j +: 8];
      lb = (alu_op == 3'b011) ? alu_r2[7:0] : alu_r2[8*j +: 8];
      r  = 0;
      case (alu_op)
        3'b000: r = int'(la) + int'(lb);
        3'b001: r = int'(la) - int'(lb);
        3'b011: r = int'(la) * int'(lb);
        default: alu_ovf = 1'b1;
      endcase
      alu_outr[8*j +: 8] = r[7:0];
      if (r > 127 || r < -128) alu_ovf = 1'b1;
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [7:0]  scalar;
    logic [39:0] a_row;
    logic [39:0] b_row;
    logic [39:0] exp_r1;
    logic [39:0] exp_wr;
    logic [2:0]  exp_aluop;
    logic        exp_ovf;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input bit restart);
    int n;
    int done_t;
    int nwr;
    int ndone;
    bit illegal;
    nwr = 0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      bank_a[i] = v.a_row;
      bank_b[i] = v.b_row;
    end
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("held_err", err, prev_err);
    chk("held_ovf", ovf_flag, prev_ovf);
    start  = 1'b1;
    op     = v.op;
    size   = v.size;
    scalar = v.scalar;
    illegal = v.exp_err;
    n = int'(v.size);
    done_t = illegal ? 1 : 2 * n + 1;
    for (int t = 1; t <= done_t; t++) begin
      bit exp_rd;
      bit exp_wr;
      @(negedge clk);
      if (t == 1) start = 1'b0;
      if (restart && t == 3) begin
        start = 1'b1;
        op    = 3'b101;
        size  = 3'd2;
      end
      if (restart && t == 4) start = 1'b0;
      exp_rd = !illegal && (t < done_t) && (t % 2 == 1);
      exp_wr = !illegal && (t < done_t) && (t % 2 == 0);
      chk("busy", busy, 1'b1);
      chk("done", done, (t == done_t));
      chk("rd_en", rd_en, exp_rd);
      chk("wr_en", wr_en, exp_wr);
      chk("alu_s", alu_s, v.size);
      if (exp_rd) chk("rd_addr", rd_addr, 40'((t - 1) / 2));
      if (exp_wr) begin
        chk("wr_addr", wr_addr, 40'((t - 2) / 2));
        chk("wr_data", wr_data, v.exp_wr);
        chk("alu_r1", alu_r1, v.exp_r1);
        chk("alu_op", alu_op, v.exp_aluop);
      end
      if (t == done_t) begin
        chk("err", err, v.exp_err);
        chk("ovf_flag", ovf_flag, v.exp_ovf);
      end
      if (wr_en) nwr++;
      if (done) ndone++;
    end
    $display("cmd op=%b size=%0d restart=%0d writes=%0d dones=%0d err=%b ovf=%b",
             v.op, v.size, restart, nwr, ndone, err, ovf_flag);
    prev_err = v.exp_err;
    prev_ovf = v.exp_ovf;
  endtask

  task automatic reset_mid_cmd();
    for (int i = 0; i < 8; i++) begin
      bank_a[i] = 40'h0505050505;
      bank_b[i] = 40'h0102030405;
    end
    @(negedge clk);
    start = 1'b1;
    op    = 3'b000;
    size  = 3'd5;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_data", wr_data, 40'h0);
    chk("rst_alu_op", alu_op, 3'b000);
    chk("rst_alu_s", alu_s, 3'b000);
    chk("rst_alu_r1", alu_r1, 40'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_ovf", ovf_flag, 1'b0);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("post_rst_wr_en", wr_en, 1'b0);
      chk("post_rst_rd_en", rd_en, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end
    $display("cmd op=000 size=5 aborted by reset");
    prev_err = 1'b0;
    prev_ovf = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 3'd3, 8'h00, 40'h0000030201, 40'h0000010101, 40'h0000030201, 40'h0000040302, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 3'd2, 8'h00, 40'hFFFFFF0102, 40'h0101010101, 40'h0000000102, 40'h0000000203, 3'b000, 1'b0, 1'b0};
    vecs[2]  = '{3'b011, 3'd2, 8'h40, 40'h0000000404, 40'hFFFFFFFFFF, 40'h0000000404, 40'h0000000000, 3'b011, 1'b1, 1'b0};
    vecs[3]  = '{3'b000, 3'd2, 8'h00, 40'h0000000101, 40'h0000000101, 40'h0000000101, 40'h0000000202, 3'b000, 1'b0, 1'b0};
    vecs[4]  = '{3'b110, 3'd2, 8'h00, 40'h0000000305, 40'h0000000000, 40'h0000000000, 40'h000000FDFB, 3'b001, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 3'd3, 8'h00, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 3'b000, 1'b0, 1'b1};
    vecs[6]  = '{3'b000, 3'd6, 8'h00, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 3'b000, 1'b0, 1'b1};
    vecs[7]  = '{3'b001, 3'd5, 8'h00, 40'h0505050505, 40'h0102030405, 40'h0505050505, 40'h0403020100, 3'b001, 1'b0, 1'b0};
    vecs[8]  = '{3'b111, 3'd4, 8'h00, 40'h1122334455, 40'h0000000000, 40'h0000000000, 40'h0000000000, 3'b111, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 3'd3, 8'h00, 40'h0000000080, 40'h0000000001, 40'h0000000080, 40'h000000007F, 3'b001, 1'b1, 1'b0};
    vecs[10] = '{3'b010, 3'd2, 8'h00, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 3'b000, 1'b0, 1'b1};
    vecs[11] = '{3'b000, 3'd1, 8'h00, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 3'b000, 1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    op = '0;
    size = '0;
    scalar = '0;
    rd_data_a = '0;
    rd_data_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_rd_en", rd_en, 1'b0);
    chk("reset_wr_en", wr_en, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_ovf", ovf_flag, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_cmd(vecs[i], 1'b0);

    run_cmd(vecs[3], 1'b1);
    reset_mid_cmd();
    run_cmd(vecs[0], 1'b0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_seq_ctrl.md
# matrix_seq_ctrl

Row sequencer for the coprocessor's 40-bit row ALU (five signed 8-bit lanes, one matrix row per operation). It accepts one matrix command from the instruction decoder and walks rows 0..size-1 of operand banks A and B. Each row is presented to the ALU with unused columns masked, and each result row is written to the result bank. A per-command sticky overflow flag and a done pulse are returned to the decoder.

## Interface
- ADDR_W, 3, row address width for the operand and result banks; rows 0..4 are used.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  3  command opcode, sampled with start.
- size  in  3  matrix dimension N (NxN), sampled with start.
- scalar  in  8  signed multiplier for op 011, sampled with start.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal command; valid from done, held until the next accepted start.
- ovf_flag  out  1  sticky overflow of the command; valid from done, held until the next accepted start.
- rd_en  out  1  bank read strobe.
- rd_addr  out  ADDR_W  row read address for A and B.
- rd_data_a, rd_data_b  in  40  row data. Registered banks: data for a read issued in cycle t is valid in cycle t+1.
- alu_op  out  3  ALU opcode.
- alu_r1, alu_r2  out  40  ALU operands.
- alu_s  out  3  matrix size forwarded to the ALU.
- alu_outr  in  40  ALU result, combinational.
- alu_ovf  in  1  ALU overflow, combinational.
- wr_en  out  1  result bank write strobe.
- wr_addr  out  ADDR_W  result row address.
- wr_data  out  40  result row.

## Operation
- Lane j (column j) occupies bits [8j+7:8j], for j = 0..4.
- Legal opcodes and their handling:
  - 000 add: alu_op 000, r1 = A, r2 = B.
  - 001 sub: alu_op 001, r1 = A, r2 = B.
  - 011 scalar multiply: alu_op 011, r1 = A, r2 lane0 = latched scalar, other r2 lanes 0.
  - 110 opposite: alu_op 001, r1 = 0, r2 = A.
  - 111 clear: no ALU use; wr_data = 0 for every row.
- Illegal commands: op 010, 100 or 101, or size outside 2..5. These go directly to DONE with err = 1. No reads, no writes, ovf_flag = 0.
- Masking: operand lanes j >= N are forced to 0 before the ALU, and wr_data lanes j >= N are forced to 0. As a result, unused lanes never contribute to alu_ovf.
- FSM states and transitions:
  - IDLE: on start go to READ with row = 0, or go to DONE if the command is illegal.
  - READ: rd_en = 1, rd_addr = row.
  - EXEC: operands are driven from rd_data; wr_en = 1, wr_addr = row, wr_data = masked alu_outr; ovf_flag |= alu_ovf. Then, if row == N-1, go to DONE; otherwise row++ and go to READ.
  - DONE: done = 1, then go to IDLE.
- Output activity by state:
  - busy = 1 in READ, EXEC and DONE.
  - alu_r1, alu_r2 and wr_* are 0 outside EXEC.
  - alu_op and alu_s hold the latched command values while busy, and are 0 in IDLE.
- start while busy is ignored, with no queuing.
- An accepted start latches op, size and scalar, and clears err and ovf_flag.

## Timing
- Reset, at any time including mid-command: state IDLE, row 0. All outputs become 0 on the next edge. No further rd_en or wr_en is issued for the aborted command.
- Start accepted at edge k (legal command): READ in cycle k+1, EXEC in k+2, then alternating. The write for row r occurs in cycle k+2+2r. done is in cycle k+2N+1.
  - N = 2: done at k+5.
  - N = 5: done at k+11.
- Illegal command: done and err in cycle k+1.
- Throughput: one row every 2 cycles. The next start is accepted in the IDLE cycle after done, i.e. there is one idle cycle between commands.
- ovf_flag and err are stable from the done cycle until the next accepted start.

## Test plan
- Add 3x3, A rows = 0x0000030201, B rows = 0x0000010101, start at edge k:
  - wr_en at k+2, k+4 and k+6 with wr_data = 0x0000040302.
  - done at k+7, ovf_flag = 0, err = 0.
- Size masking: size 2, A = 0xFFFFFF0102, B = 0x0101010101 -> wr_data = 0x0000000203, and ovf_flag = 0 (the 0xFF lanes are masked).
- Overflow and scalar multiply: size 2, op 011, scalar = 0x40, A row0 = 0x0000000404 -> ovf_flag = 1 at done. Then a following clean add command -> ovf_flag = 0 at its done.
- Opposite, then illegal command:
  - Opposite: op 110, size 2, A row = 0x0000000305 -> alu_op = 001, alu_r1 = 0.
  - Illegal: op 101, or size 6 -> done at k+1, err = 1, no rd_en or wr_en.
- Reset mid-command: size 5 add, rst asserted at k+5 -> all outputs 0 from k+6, no wr_en after reset, busy = 0. A new start is accepted normally afterwards.
- Start while busy: a second start at k+3 is ignored. Exactly N writes and a single done occur.
